// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller for a five-stage RISC-V core.
// Freezes the whole pipe on data-memory and mul/div waits, flushes on taken
// branches, inserts a bubble on load-use, injects a NOP on instruction-fetch
// wait, and keeps saturating stall/flush performance counters.
module riscv_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             muldiv_op,
    input  logic             muldiv_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             muldiv_go,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        MDWAIT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             dmiss_s;
    logic             freeze_s;
    logic             load_use_s;
    logic             br_flush_s;
    logic             pc_stall_s;
    logic             if_id_stall_s;
    logic             if_id_flush_s;
    logic             id_ex_stall_s;
    logic             id_ex_flush_s;
    logic             ex_mem_stall_s;
    logic             muldiv_go_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Load-use detection; x0 is hardwired so it can never create a dependency.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_mem_read && (ex_rd != 5'd0) &&
            ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Next state, freeze condition and mul/div launch pulse; data wait wins over mul/div entry.
    always_comb begin
        state_nxt_s = state_r;
        freeze_s    = 1'b0;
        muldiv_go_s = 1'b0;
        dmiss_s     = mem_req && !dmem_ready;
        case (state_r)
            RUN: begin
                if (dmiss_s) begin
                    freeze_s    = 1'b1;
                    state_nxt_s = DWAIT;
                end else if (muldiv_op) begin
                    freeze_s    = 1'b1;
                    muldiv_go_s = 1'b1;
                    state_nxt_s = MDWAIT;
                end else begin
                    freeze_s    = 1'b0;
                    state_nxt_s = RUN;
                end
            end
            DWAIT: begin
                if (dmem_ready) begin
                    freeze_s    = 1'b0;
                    state_nxt_s = RUN;
                end else begin
                    freeze_s    = 1'b1;
                    state_nxt_s = DWAIT;
                end
            end
            MDWAIT: begin
                if (muldiv_done) begin
                    freeze_s    = 1'b0;
                    state_nxt_s = RUN;
                end else begin
                    freeze_s    = 1'b1;
                    state_nxt_s = MDWAIT;
                end
            end
            default: begin
                freeze_s    = 1'b0;
                state_nxt_s = RUN;
            end
        endcase
    end

    // Stall/flush decode: freeze, then branch redirect, then load-use bubble, then fetch NOP.
    always_comb begin
        pc_stall_s     = 1'b0;
        if_id_stall_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_stall_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_stall_s = 1'b0;
        br_flush_s     = 1'b0;
        if (freeze_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ex_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
        end else if (branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            br_flush_s    = 1'b1;
        end else if (load_use_s) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (!imem_ready) begin
            pc_stall_s    = 1'b1;
            if_id_flush_s = 1'b1;
        end else begin
            pc_stall_s = 1'b0;
        end
    end

    // State register; reset aborts any pending data or mul/div wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating stall counter, counts every cycle the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (pc_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating flush counter, counts branch-redirect cycles only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (br_flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign pc_stall     = pc_stall_s;
    assign if_id_stall  = if_id_stall_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_stall  = id_ex_stall_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign ex_mem_stall = ex_mem_stall_s;
    assign muldiv_go    = muldiv_go_s;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: doc/riscv_hazard_ctrl.md
RISCV_HAZARD_CTRL -- requirements
Module: riscv_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1); reset is asynchronous and active-low.
REQ-003 SHALL have inputs id_rs1, id_rs2 (5 each, ID source registers), plus id_use_rs1 and id_use_rs2 (1 each, source actually read).
REQ-004 SHALL have inputs ex_rd (5, EX destination register) and ex_mem_read (1, EX holds a load).
REQ-005 SHALL have inputs branch_taken (1, EX redirect), imem_ready (1, fetch data valid), mem_req (1, MEM stage access) and dmem_ready (1, data memory ack).
REQ-006 SHALL have inputs muldiv_op (1, level; EX holds a mul/div) and muldiv_done (1, pulse; unit result valid).
REQ-007 SHALL have outputs pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall and muldiv_go (1 each).
REQ-008 SHALL have outputs stall_cnt and flush_cnt (CNT_W each, performance counters).

Function
REQ-009 SHALL implement FSM states RUN, DWAIT and MDWAIT, held in state registers; all stall/flush outputs are combinational from the state and inputs.
REQ-010 freeze SHALL equal (RUN and mem_req and !dmem_ready) or (DWAIT and !dmem_ready) or (RUN and muldiv_op) or (MDWAIT and !muldiv_done).
REQ-011 freeze=1 SHALL assert pc_stall, if_id_stall, id_ex_stall and ex_mem_stall, and SHALL force every flush output to 0.
REQ-012 RUN->DWAIT SHALL occur on mem_req and !dmem_ready; DWAIT->RUN on dmem_ready, which is an unfrozen cycle.
REQ-013 RUN with muldiv_op and no DWAIT entry SHALL pulse muldiv_go for exactly one cycle and go to MDWAIT; the DWAIT condition has priority over muldiv entry.
REQ-014 MDWAIT SHALL keep muldiv_go=0 and return to RUN in the muldiv_done cycle, which is unfrozen; muldiv_done seen in RUN SHALL be ignored.
REQ-015 If unfrozen and branch_taken, the block SHALL assert if_id_flush=1 and id_ex_flush=1 with pc_stall=0 and if_id_stall=0; this takes priority over load-use and fetch wait.
REQ-016 Load-use SHALL be defined as ex_mem_read and ex_rd!=0 and ((id_use_rs1 and ex_rd==id_rs1) or (id_use_rs2 and ex_rd==id_rs2)).
REQ-017 If unfrozen, with no branch and load-use, the block SHALL assert pc_stall=1, if_id_stall=1 and id_ex_flush=1 for exactly that cycle, inserting one bubble.
REQ-018 If unfrozen, with no branch, no load-use and !imem_ready, the block SHALL assert pc_stall=1 and if_id_flush=1, injecting a NOP into IF/ID.
REQ-019 if_id_stall and if_id_flush SHALL never both be 1; id_ex_stall and id_ex_flush SHALL never both be 1.
REQ-020 stall_cnt SHALL increment on every cycle with pc_stall=1 and saturate at all-ones.
REQ-021 flush_cnt SHALL increment on every cycle satisfying REQ-015 and saturate at all-ones.
REQ-022 All outputs not named by an active rule SHALL be 0.

Reset
REQ-023 While rst_n=0 the block SHALL hold state=RUN and stall_cnt=flush_cnt=0, taking effect immediately regardless of clk.
REQ-024 Reset asserted in DWAIT or MDWAIT SHALL abort the wait; after release muldiv_go SHALL re-pulse if muldiv_op is still high.
REQ-025 Stall/flush outputs during reset SHALL follow REQ-010 to REQ-018 evaluated with state=RUN.

Verification
REQ-026 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cnt=1.
REQ-027 Load-use on x0: ex_rd=0=id_rs1 -> no stall, all outputs 0.
REQ-028 Branch with load-use: branch_taken=1 together with a load-use hit -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1.
REQ-029 Data wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 frozen cycles; a concurrent branch_taken produces no flush until the unfrozen cycle; stall_cnt=3.
REQ-030 Mul/div: muldiv_op=1 held, muldiv_done after 4 cycles -> muldiv_go pulses once in cycle 1; freeze lasts 4 cycles; unfrozen in the done cycle.
REQ-031 Reset mid-MDWAIT: rst_n low for 1 cycle -> counters 0, state RUN; muldiv_go re-pulses on the first cycle after release.
